// File: rtl/dispatch_stage.sv
// rtl/dispatch_stage.sv - decode/rename/forward dispatch stage with one-entry output register; optional DISPATCH_HOLD_SNOOP_EN
module dispatch_stage #(
   parameter int ROB_ID_W = 4,
   parameter int XLEN     = 32,
   parameter int CDB_NUM  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [XLEN-1:0]              in_pc,
   input  logic [XLEN-1:0]              in_next_pc,
   input  logic [31:0]                  in_inst,
   output logic [4:0]                   rs1_idx,
   output logic [4:0]                   rs2_idx,
   input  logic [XLEN-1:0]              rf_vj,
   input  logic [XLEN-1:0]              rf_vk,
   input  logic [ROB_ID_W-1:0]          rf_qj,
   input  logic [ROB_ID_W-1:0]          rf_qk,
   output logic [ROB_ID_W-1:0]          rob_qj,
   output logic [ROB_ID_W-1:0]          rob_qk,
   input  logic                         rob_vj_ok,
   input  logic                         rob_vk_ok,
   input  logic [XLEN-1:0]              rob_vj,
   input  logic [XLEN-1:0]              rob_vk,
   input  logic [ROB_ID_W-1:0]          rob_free_tag,
   input  logic                         rob_full,
   output logic                         rob_we,
   output logic [1:0]                   rob_kind,
   output logic [4:0]                   rob_rd,
   output logic [XLEN-1:0]              rob_next_pc,
   output logic                         ren_we,
   output logic [4:0]                   ren_rd,
   output logic [ROB_ID_W-1:0]          ren_tag,
   input  logic [CDB_NUM*ROB_ID_W-1:0]  cdb_tag,
   input  logic [CDB_NUM*XLEN-1:0]      cdb_val,
   output logic                         out_valid,
   output logic                         out_lsb,
   input  logic                         rs_ready,
   input  logic                         lsb_ready,
   output logic [ROB_ID_W-1:0]          out_tag,
   output logic [10:0]                  out_op,
   output logic [ROB_ID_W-1:0]          out_qj,
   output logic [ROB_ID_W-1:0]          out_qk,
   output logic [XLEN-1:0]              out_vj,
   output logic [XLEN-1:0]              out_vk,
   output logic [XLEN-1:0]              out_imm,
   output logic [XLEN-1:0]              out_pc
);

   // op field is {alt (sub/sra), funct3, opcode}
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]          opcode;
   logic [4:0]          dec_rd;
   logic [2:0]          dec_f3;
   logic                dec_alt;
   logic [31:0]         imm32;
   logic [XLEN-1:0]     dec_imm;
   logic [10:0]         dec_op;
   logic                is_load;
   logic                is_store;
   logic                is_branch;
   logic                tgt_ready;
   logic                accept;
   logic [ROB_ID_W-1:0] res_qj;
   logic [ROB_ID_W-1:0] res_qk;
   logic [XLEN-1:0]     res_vj;
   logic [XLEN-1:0]     res_vk;
   logic [XLEN:0]       fwd_j;
   logic [XLEN:0]       fwd_k;

   // Lowest-index CDB slot broadcasting a nonzero tag; returns {hit, value}
   function automatic logic [XLEN:0] cdb_find(input logic [ROB_ID_W-1:0] tag,
                                              input logic [CDB_NUM*ROB_ID_W-1:0] tags,
                                              input logic [CDB_NUM*XLEN-1:0] vals);
      logic [XLEN:0] r;
      r = '0;
      for (int k = CDB_NUM - 1; k >= 0; k--) begin
         if (tag != '0 && tags[k*ROB_ID_W +: ROB_ID_W] == tag) begin
            r = {1'b1, vals[k*XLEN +: XLEN]};
         end
      end
      return r;
   endfunction

   assign opcode  = in_inst[6:0];
   assign dec_imm = XLEN'($signed(imm32));
   assign dec_op  = {dec_alt, dec_f3, opcode};

   // Instruction decode: register indices, immediate, class flags
   always_comb begin
      dec_rd    = '0;
      rs1_idx   = '0;
      rs2_idx   = '0;
      dec_f3    = '0;
      dec_alt   = 1'b0;
      imm32     = '0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            dec_rd = in_inst[11:7];
            imm32  = {in_inst[31:12], 12'b0};
         end
         OPC_JAL: begin
            dec_rd = in_inst[11:7];
            imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         end
         OPC_JALR: begin
            dec_rd  = in_inst[11:7];
            rs1_idx = in_inst[19:15];
            dec_f3  = in_inst[14:12];
            imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_BRANCH: begin
            rs1_idx   = in_inst[19:15];
            rs2_idx   = in_inst[24:20];
            dec_f3    = in_inst[14:12];
            imm32     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            is_branch = 1'b1;
         end
         OPC_LOAD: begin
            dec_rd  = in_inst[11:7];
            rs1_idx = in_inst[19:15];
            dec_f3  = in_inst[14:12];
            imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            is_load = 1'b1;
         end
         OPC_STORE: begin
            rs1_idx  = in_inst[19:15];
            rs2_idx  = in_inst[24:20];
            dec_f3   = in_inst[14:12];
            imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            is_store = 1'b1;
         end
         OPC_OPIMM: begin
            dec_rd  = in_inst[11:7];
            rs1_idx = in_inst[19:15];
            dec_f3  = in_inst[14:12];
            dec_alt = (in_inst[14:12] == 3'b101) && in_inst[30];
            imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
         end
         OPC_OP: begin
            dec_rd  = in_inst[11:7];
            rs1_idx = in_inst[19:15];
            rs2_idx = in_inst[24:20];
            dec_f3  = in_inst[14:12];
            dec_alt = in_inst[30];
         end
         default: ;
      endcase
   end

   assign rob_qj    = rf_qj;
   assign rob_qk    = rf_qk;
   assign tgt_ready = out_lsb ? lsb_ready : rs_ready;
   assign in_ready  = rdy && !flush && !rob_full && (!out_valid || tgt_ready);
   assign accept    = in_valid && in_ready;
   assign fwd_j     = cdb_find(rf_qj, cdb_tag, cdb_val);
   assign fwd_k     = cdb_find(rf_qk, cdb_tag, cdb_val);

   // Operand resolution: register file, then ROB, then CDB, else keep tag
   always_comb begin
      res_qj = rf_qj;
      res_vj = '0;
      if (rf_qj == '0) begin
         res_qj = '0;
         res_vj = rf_vj;
      end else if (rob_vj_ok) begin
         res_qj = '0;
         res_vj = rob_vj;
      end else if (fwd_j[XLEN]) begin
         res_qj = '0;
         res_vj = fwd_j[XLEN-1:0];
      end
      res_qk = rf_qk;
      res_vk = '0;
      if (rf_qk == '0) begin
         res_qk = '0;
         res_vk = rf_vk;
      end else if (rob_vk_ok) begin
         res_qk = '0;
         res_vk = rob_vk;
      end else if (fwd_k[XLEN]) begin
         res_qk = '0;
         res_vk = fwd_k[XLEN-1:0];
      end
   end

`ifdef DISPATCH_HOLD_SNOOP_EN
   logic [XLEN:0] snoop_j;
   logic [XLEN:0] snoop_k;
   assign snoop_j = cdb_find(out_qj, cdb_tag, cdb_val);
   assign snoop_k = cdb_find(out_qk, cdb_tag, cdb_val);
`endif

   // Output packet register plus one-cycle ROB allocate and rename pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid   <= 1'b0;
         out_lsb     <= 1'b0;
         out_tag     <= '0;
         out_op      <= '0;
         out_qj      <= '0;
         out_qk      <= '0;
         out_vj      <= '0;
         out_vk      <= '0;
         out_imm     <= '0;
         out_pc      <= '0;
         rob_we      <= 1'b0;
         rob_kind    <= '0;
         rob_rd      <= '0;
         rob_next_pc <= '0;
         ren_we      <= 1'b0;
         ren_rd      <= '0;
         ren_tag     <= '0;
      end else if (rdy) begin
         if (flush) begin
            out_valid <= 1'b0;
            rob_we    <= 1'b0;
            ren_we    <= 1'b0;
         end else if (accept) begin
            out_valid   <= 1'b1;
            out_lsb     <= is_load || is_store;
            out_tag     <= rob_free_tag;
            out_op      <= dec_op;
            out_qj      <= res_qj;
            out_qk      <= res_qk;
            out_vj      <= res_vj;
            out_vk      <= res_vk;
            out_imm     <= dec_imm;
            out_pc      <= in_pc;
            rob_we      <= 1'b1;
            rob_kind    <= is_store ? 2'd1 : (is_branch ? 2'd2 : 2'd0);
            rob_rd      <= dec_rd;
            rob_next_pc <= in_next_pc;
            ren_we      <= (dec_rd != 5'd0);
            ren_rd      <= dec_rd;
            ren_tag     <= rob_free_tag;
         end else begin
            rob_we <= 1'b0;
            ren_we <= 1'b0;
            if (out_valid && tgt_ready) begin
               out_valid <= 1'b0;
            end
`ifdef DISPATCH_HOLD_SNOOP_EN
            if (out_valid && snoop_j[XLEN]) begin
               out_qj <= '0;
               out_vj <= snoop_j[XLEN-1:0];
            end
            if (out_valid && snoop_k[XLEN]) begin
               out_qk <= '0;
               out_vk <= snoop_k[XLEN-1:0];
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb/tb_dispatch_stage.sv - randomized self-checking bench for dispatch_stage against a packet-level model
module tb_dispatch_stage;

   localparam int RW = 4;
   localparam int XL = 32;
   localparam int CN = 2;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic clk = 1'b0;
   logic rst, rdy, flush, in_valid, in_ready;
   logic [XL-1:0] in_pc, in_next_pc;
   logic [31:0] in_inst;
   logic [4:0] rs1_idx, rs2_idx;
   logic [XL-1:0] rf_vj, rf_vk, rob_vj, rob_vk;
   logic [RW-1:0] rf_qj, rf_qk, rob_qj, rob_qk, rob_free_tag;
   logic rob_vj_ok, rob_vk_ok, rob_full;
   logic rob_we, ren_we, out_valid, out_lsb, rs_ready, lsb_ready;
   logic [1:0] rob_kind;
   logic [4:0] rob_rd, ren_rd;
   logic [XL-1:0] rob_next_pc;
   logic [RW-1:0] ren_tag, out_tag, out_qj, out_qk;
   logic [CN*RW-1:0] cdb_tag;
   logic [CN*XL-1:0] cdb_val;
   logic [10:0] out_op;
   logic [XL-1:0] out_vj, out_vk, out_imm, out_pc;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [RW-1:0] q;
      logic [XL-1:0] v;
   } opnd_t;

   // reference model state (what the outputs should be)
   logic          m_valid, m_lsb, m_rob_we, m_ren_we;
   logic [RW-1:0] m_tag, m_qj, m_qk, m_ren_tag;
   logic [10:0]   m_op;
   logic [XL-1:0] m_vj, m_vk, m_imm, m_pc, m_npc;
   logic [1:0]    m_kind;
   logic [4:0]    m_rob_rd, m_ren_rd;

   // properties of the instruction currently on in_inst
   logic [4:0]  cur_rd, cur_rs1, cur_rs2;
   logic [10:0] cur_op;
   logic [31:0] cur_imm;
   logic        cur_ls;
   logic [1:0]  cur_kind;

   dispatch_stage #(.ROB_ID_W(RW), .XLEN(XL), .CDB_NUM(CN)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_next_pc(in_next_pc), .in_inst(in_inst),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .rf_vj(rf_vj), .rf_vk(rf_vk), .rf_qj(rf_qj), .rf_qk(rf_qk),
      .rob_qj(rob_qj), .rob_qk(rob_qk),
      .rob_vj_ok(rob_vj_ok), .rob_vk_ok(rob_vk_ok), .rob_vj(rob_vj), .rob_vk(rob_vk),
      .rob_free_tag(rob_free_tag), .rob_full(rob_full),
      .rob_we(rob_we), .rob_kind(rob_kind), .rob_rd(rob_rd), .rob_next_pc(rob_next_pc),
      .ren_we(ren_we), .ren_rd(ren_rd), .ren_tag(ren_tag),
      .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .out_valid(out_valid), .out_lsb(out_lsb), .rs_ready(rs_ready), .lsb_ready(lsb_ready),
      .out_tag(out_tag), .out_op(out_op), .out_qj(out_qj), .out_qk(out_qk),
      .out_vj(out_vj), .out_vk(out_vk), .out_imm(out_imm), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic opnd_t cdb_search(input logic [RW-1:0] q);
      opnd_t r;
      r.q = q;
      r.v = '0;
      for (int k = 0; k < CN; k++) begin
         if (r.q != '0 && cdb_tag[k*RW +: RW] == q) begin
            r.q = '0;
            r.v = cdb_val[k*XL +: XL];
            break;
         end
      end
      return r;
   endfunction

   function automatic opnd_t resolve(input logic [RW-1:0] q, input logic [XL-1:0] v,
                                     input logic ok, input logic [XL-1:0] rv);
      opnd_t r;
      if (q == '0) begin
         r.q = '0; r.v = v;
      end else if (ok) begin
         r.q = '0; r.v = rv;
      end else begin
         r = cdb_search(q);
      end
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_lsb = 0; m_rob_we = 0; m_ren_we = 0;
      m_tag = '0; m_qj = '0; m_qk = '0; m_ren_tag = '0; m_op = '0;
      m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_npc = '0;
      m_kind = '0; m_rob_rd = '0; m_ren_rd = '0;
   endtask

   // Builds an instruction from its fields; kind 0 add,1 sub,2 addi,3 lw,4 sw,5 beq/bne,6 lui
   task automatic make_inst(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] r);
      logic [11:0] i12;
      logic [12:0] b13;
      logic [19:0] u20;
      logic [2:0]  f3;
      logic [6:0]  opc;
      logic        alt;
      i12 = r[11:0];
      b13 = {r[12:1], 1'b0};
      u20 = r[31:12];
      cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2;
      cur_ls = 0; cur_kind = 2'd0; alt = 0; f3 = 3'd0; opc = OPC_OP;
      cur_imm = 32'($signed(i12));
      case (kind)
         0, 1: begin
            alt = (kind == 1);
            in_inst = {alt ? 7'b0100000 : 7'b0000000, rs2, rs1, f3, rd, OPC_OP};
            cur_imm = '0;
         end
         2: begin
            opc = OPC_OPIMM; cur_rs2 = 0;
            in_inst = {i12, rs1, f3, rd, opc};
         end
         3: begin
            opc = OPC_LOAD; f3 = 3'd2; cur_rs2 = 0; cur_ls = 1;
            in_inst = {i12, rs1, f3, rd, opc};
         end
         4: begin
            opc = OPC_STORE; f3 = 3'd2; cur_rd = 0; cur_ls = 1; cur_kind = 2'd1;
            in_inst = {i12[11:5], rs2, rs1, f3, i12[4:0], opc};
         end
         5: begin
            opc = OPC_BRANCH; f3 = r[0] ? 3'd1 : 3'd0; cur_rd = 0; cur_kind = 2'd2;
            cur_imm = 32'($signed(b13));
            in_inst = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], opc};
         end
         default: begin
            opc = OPC_LUI; cur_rs1 = 0; cur_rs2 = 0;
            cur_imm = {u20, 12'b0};
            in_inst = {u20, rd, opc};
         end
      endcase
      cur_op = {alt, f3, opc};
   endtask

   task automatic set_idle();
      rdy = 1; flush = 0; rob_full = 0; in_valid = 0;
      rs_ready = 1; lsb_ready = 1;
      rf_qj = '0; rf_qk = '0; rf_vj = '0; rf_vk = '0;
      rob_vj_ok = 0; rob_vk_ok = 0; rob_vj = '0; rob_vk = '0;
      rob_free_tag = '0; cdb_tag = '0; cdb_val = '0;
      in_pc = '0; in_next_pc = '0;
      make_inst(0, 5'd0, 5'd0, 5'd0, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
      check({tag, ".out_lsb"}, 64'(out_lsb), 64'd0);
      check({tag, ".out_tag"}, 64'(out_tag), 64'd0);
      check({tag, ".out_op"}, 64'(out_op), 64'd0);
      check({tag, ".out_qj"}, 64'(out_qj), 64'd0);
      check({tag, ".out_qk"}, 64'(out_qk), 64'd0);
      check({tag, ".out_vj"}, 64'(out_vj), 64'd0);
      check({tag, ".out_vk"}, 64'(out_vk), 64'd0);
      check({tag, ".out_imm"}, 64'(out_imm), 64'd0);
      check({tag, ".out_pc"}, 64'(out_pc), 64'd0);
      check({tag, ".rob_we"}, 64'(rob_we), 64'd0);
      check({tag, ".rob_kind"}, 64'(rob_kind), 64'd0);
      check({tag, ".rob_rd"}, 64'(rob_rd), 64'd0);
      check({tag, ".rob_next_pc"}, 64'(rob_next_pc), 64'd0);
      check({tag, ".ren_we"}, 64'(ren_we), 64'd0);
      check({tag, ".ren_rd"}, 64'(ren_rd), 64'd0);
      check({tag, ".ren_tag"}, 64'(ren_tag), 64'd0);
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs
   task automatic step();
      logic  tgt, e_ready, acc;
      opnd_t oj, ok;
      #1;
      tgt     = m_lsb ? lsb_ready : rs_ready;
      e_ready = rdy && !flush && !rob_full && (!m_valid || tgt);
      acc     = in_valid && e_ready;
      check("in_ready", 64'(in_ready), 64'(e_ready));
      check("rs1_idx", 64'(rs1_idx), 64'(cur_rs1));
      check("rs2_idx", 64'(rs2_idx), 64'(cur_rs2));
      check("rob_qj", 64'(rob_qj), 64'(rf_qj));
      check("rob_qk", 64'(rob_qk), 64'(rf_qk));
      if (rdy) begin
         if (flush) begin
            m_valid = 0; m_rob_we = 0; m_ren_we = 0;
         end else if (acc) begin
            oj = resolve(rf_qj, rf_vj, rob_vj_ok, rob_vj);
            ok = resolve(rf_qk, rf_vk, rob_vk_ok, rob_vk);
            m_valid = 1; m_lsb = cur_ls; m_tag = rob_free_tag; m_op = cur_op;
            m_qj = oj.q; m_vj = oj.v; m_qk = ok.q; m_vk = ok.v;
            m_imm = cur_imm; m_pc = in_pc;
            m_rob_we = 1; m_kind = cur_kind; m_rob_rd = cur_rd; m_npc = in_next_pc;
            m_ren_we = (cur_rd != 0); m_ren_rd = cur_rd; m_ren_tag = rob_free_tag;
         end else begin
            m_rob_we = 0; m_ren_we = 0;
`ifdef DISPATCH_HOLD_SNOOP_EN
            if (m_valid) begin
               oj = cdb_search(m_qj);
               ok = cdb_search(m_qk);
               if (oj.q != m_qj) begin m_qj = '0; m_vj = oj.v; end
               if (ok.q != m_qk) begin m_qk = '0; m_vk = ok.v; end
            end
`endif
            if (m_valid && tgt) m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("rob_we", 64'(rob_we), 64'(m_rob_we));
      check("ren_we", 64'(ren_we), 64'(m_ren_we));
      if (m_valid) begin
         check("out_lsb", 64'(out_lsb), 64'(m_lsb));
         check("out_tag", 64'(out_tag), 64'(m_tag));
         check("out_op", 64'(out_op), 64'(m_op));
         check("out_qj", 64'(out_qj), 64'(m_qj));
         check("out_qk", 64'(out_qk), 64'(m_qk));
         check("out_vj", 64'(out_vj), 64'(m_vj));
         check("out_vk", 64'(out_vk), 64'(m_vk));
         check("out_imm", 64'(out_imm), 64'(m_imm));
         check("out_pc", 64'(out_pc), 64'(m_pc));
      end
      if (m_rob_we) begin
         check("rob_kind", 64'(rob_kind), 64'(m_kind));
         check("rob_rd", 64'(rob_rd), 64'(m_rob_rd));
         check("rob_next_pc", 64'(rob_next_pc), 64'(m_npc));
      end
      if (m_ren_we) begin
         check("ren_rd", 64'(ren_rd), 64'(m_ren_rd));
         check("ren_tag", 64'(ren_tag), 64'(m_ren_tag));
      end
      @(negedge clk);
   endtask

   task automatic randomize_inputs();
      rdy          = ($urandom_range(0, 9) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      rob_full     = ($urandom_range(0, 9) == 0);
      in_valid     = ($urandom_range(0, 4) != 0);
      rs_ready     = ($urandom_range(0, 3) != 0);
      lsb_ready    = ($urandom_range(0, 3) != 0);
      rf_qj        = $urandom_range(0, 1) ? '0 : RW'($urandom_range(1, 5));
      rf_qk        = $urandom_range(0, 1) ? '0 : RW'($urandom_range(1, 5));
      rf_vj        = $urandom;
      rf_vk        = $urandom;
      rob_vj_ok    = ($urandom_range(0, 2) == 0);
      rob_vk_ok    = ($urandom_range(0, 2) == 0);
      rob_vj       = $urandom;
      rob_vk       = $urandom;
      rob_free_tag = RW'($urandom_range(0, 15));
      for (int k = 0; k < CN; k++) begin
         cdb_tag[k*RW +: RW] = RW'($urandom_range(0, 5));
         cdb_val[k*XL +: XL] = $urandom;
      end
      in_pc      = $urandom;
      in_next_pc = $urandom;
      make_inst($urandom_range(0, 6), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), $urandom);
   endtask

   initial begin
      rst = 0;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1;

      // add x3,x1,x2 with register-file values
      make_inst(0, 5'd3, 5'd1, 5'd2, 32'd0);
      rf_vj = 5; rf_vk = 7; rob_free_tag = 2; in_valid = 1;
      step();
      check("add.out_vj", 64'(out_vj), 64'd5);
      check("add.out_vk", 64'(out_vk), 64'd7);
      check("add.ren_rd", 64'(ren_rd), 64'd3);
      check("add.ren_tag", 64'(ren_tag), 64'd2);

      // lw whose base is forwarded from CDB slot 1
      make_inst(3, 5'd6, 5'd4, 5'd0, 32'h10);
      rf_qj = 4; rob_vj_ok = 0; cdb_tag = {4'd4, 4'd0}; cdb_val = {32'h100, 32'h0};
      rob_free_tag = 3;
      step();
      check("lw.out_lsb", 64'(out_lsb), 64'd1);
      check("lw.out_qj", 64'(out_qj), 64'd0);
      check("lw.out_vj", 64'(out_vj), 64'h100);

      // sw then beq: ROB kinds
      set_idle();
      make_inst(4, 5'd0, 5'd1, 5'd2, 32'h7f4);
      in_valid = 1;
      step();
      check("sw.rob_kind", 64'(rob_kind), 64'd1);
      check("sw.ren_we", 64'(ren_we), 64'd0);
      make_inst(5, 5'd0, 5'd1, 5'd2, 32'h1ffc);
      in_next_pc = 32'h8000_0040;
      step();
      check("beq.rob_kind", 64'(rob_kind), 64'd2);
      check("beq.rob_next_pc", 64'(rob_next_pc), 64'h8000_0040);

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst = 0;
            #1;
            check_all_zero("async_reset");
            model_reset();
            #1;
            rst = 1;
            @(negedge clk);
         end
         randomize_inputs();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
